// File: rtl/t_toggle_decoder.sv
`default_nettype none
// ============================================================================
// Module   : t_toggle_decoder
// Purpose  : Receive end of a T flip-flop toggle encoding. The upstream
//            encoder flips its q output whenever its t input is 1, so the
//            original data bit is recovered as t = q xor (previous q). The
//            recovered bits are assembled LSB-first into WIDTH-bit words
//            that are handed out through a one-entry valid/ready output
//            register. A completed word that finds the output register still
//            occupied is dropped, and a sticky overflow flag records the loss.
//
// Ports    : clk        in   rising-edge clock for all state
//            rst_n      in   asynchronous active-low reset
//            q_in       in   toggle-encoded line from the encoder flip-flop
//            en         in   sample qualifier, q_in used only when en=1
//            clr        in   synchronous clear of partial word and overflow
//            word_out   out  [WIDTH] last completed word
//            word_valid out  word_out holds an unconsumed word
//            word_ready in   consumer accepts word_out while word_valid=1
//            overflow   out  sticky, a completed word was dropped
//            bit_cnt    out  [CNT_W] bits collected in the current word
//
// Revision : 1.0  initial release
// ============================================================================
module t_toggle_decoder #(
  parameter int WIDTH = 8,            // word width, must equal 2**CNT_W
  parameter int CNT_W = 3             // bit counter width
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             q_in,
  input  logic             en,
  input  logic             clr,
  output logic [WIDTH-1:0] word_out,
  output logic             word_valid,
  input  logic             word_ready,
  output logic             overflow,
  output logic [CNT_W-1:0] bit_cnt
);

  // Index of the last bit in a word; reaching it completes the word.
  localparam logic [CNT_W-1:0] C_LAST_BIT = CNT_W'(WIDTH - 1);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic             q_prev_q,     q_prev_d;     // last sampled line level
  logic [WIDTH-1:0] shreg_q,      shreg_d;      // partial word, fills from MSB
  logic [CNT_W-1:0] bit_cnt_q,    bit_cnt_d;
  logic [WIDTH-1:0] word_out_q,   word_out_d;
  logic             word_valid_q, word_valid_d;
  logic             overflow_q,   overflow_d;

  // --------------------------------------------------------------------------
  // Decode datapath
  // --------------------------------------------------------------------------
  logic             t_bit;        // recovered data bit for this sample
  logic             sample;       // q_in is consumed this cycle
  logic             word_done;    // this sample completes a word
  logic [WIDTH-1:0] shreg_next;   // partial word with this sample shifted in
  logic             out_free;     // output register can take a new word

  assign t_bit      = q_in ^ q_prev_q;
  assign sample     = en & ~clr;
  // New bits enter at the MSB and move toward bit 0, so after WIDTH samples
  // the first received bit sits at bit 0 (LSB-first assembly).
  assign shreg_next = {t_bit, shreg_q[WIDTH-1:1]};
  assign word_done  = sample && (bit_cnt_q == C_LAST_BIT);
  // The slot is free when empty or when the current word is being taken in
  // this same cycle; the latter allows a load on the accepting edge.
  assign out_free   = ~word_valid_q | word_ready;

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    q_prev_d     = q_prev_q;
    shreg_d      = shreg_q;
    bit_cnt_d    = bit_cnt_q;
    word_out_d   = word_out_q;
    word_valid_d = word_valid_q;
    overflow_d   = overflow_q;

    // Input side: clr wins over en. Loading q_prev from q_in on clr makes the
    // current line level the new reference, so an encoder that was restarted
    // or drifted out of step is picked up cleanly without a spurious bit.
    if (clr) begin
      q_prev_d   = q_in;
      shreg_d    = '0;
      bit_cnt_d  = '0;
      overflow_d = 1'b0;
    end else if (en) begin
      q_prev_d   = q_in;
      shreg_d    = shreg_next;
      // WIDTH is a power of two, so natural wrap returns the count to zero
      // right after the last bit.
      bit_cnt_d  = bit_cnt_q + 1'b1;
    end

    // Output side: independent of clr so a pending word survives a clear.
    if (word_done) begin
      if (out_free) begin
        word_out_d   = shreg_next;
        word_valid_d = 1'b1;
      end else begin
        overflow_d   = 1'b1;
      end
    end else if (word_valid_q && word_ready) begin
      word_valid_d = 1'b0;
    end
  end

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  // q_prev resets to 0 to match the encoder flip-flop's own reset value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_prev_q     <= 1'b0;
      shreg_q      <= '0;
      bit_cnt_q    <= '0;
      word_out_q   <= '0;
      word_valid_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      q_prev_q     <= q_prev_d;
      shreg_q      <= shreg_d;
      bit_cnt_q    <= bit_cnt_d;
      word_out_q   <= word_out_d;
      word_valid_q <= word_valid_d;
      overflow_q   <= overflow_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign word_out   = word_out_q;
  assign word_valid = word_valid_q;
  assign overflow   = overflow_q;
  assign bit_cnt    = bit_cnt_q;

endmodule
`default_nettype wire

// File: doc/t_toggle_decoder.md
Name: t_toggle_decoder

Overview:
Decoder end of the T flip-flop toggle encoding. Upstream, a T flip-flop driven by a data bit stream produces a toggle-encoded line q (q flips when t=1). This block samples q, recovers the original t bits (t = q xor previous q), and deserializes them LSB-first into WIDTH-bit words. Words are presented on a valid/ready output register with sticky overflow reporting.

Parameters:
WIDTH, 8, recovered word width in bits; must equal 2**CNT_W.
CNT_W, 3, width of the bit counter.

Ports:
clk  input  1  single clock; all state updates on rising edge.
rst_n  input  1  asynchronous active-low reset.
q_in  input  1  toggle-encoded line from the T flip-flop.
en  input  1  sample qualifier; q_in is consumed only on cycles with en=1.
clr  input  1  synchronous clear of partial-word state and overflow.
word_out  output  WIDTH  last completed word.
word_valid  output  1  word_out holds an unconsumed word.
word_ready  input  1  consumer accepts word_out when word_valid=1.
overflow  output  1  sticky: a completed word was dropped.
bit_cnt  output  CNT_W  bits collected in the current partial word.

Behaviour:
- Reset (rst_n=0, asynchronous): q_prev=0, shift register=0, bit_cnt=0, word_out=0, word_valid=0, overflow=0. q_prev=0 matches the encoder flip-flop's reset value of q=0.
- Decode, on a cycle with en=1 and clr=0:
  - t_bit = q_in ^ q_prev.
  - q_prev <= q_in.
  - shreg <= {t_bit, shreg[WIDTH-1:1]} (LSB-first assembly).
  - bit_cnt <= bit_cnt+1, wrapping from WIDTH-1 to 0.
- en=0: q_prev, shreg and bit_cnt hold. Changes on q_in during en=0 cycles are ignored. The next decode compares against the last sampled q.
- Word complete: en=1, clr=0 and bit_cnt==WIDTH-1. The completed word is {t_bit, shreg[WIDTH-1:1]}.
- Output register, evaluated on a word-complete cycle:
  - If word_valid=0, or word_valid=1 and word_ready=1: word_out <= completed word; word_valid=1 on the next cycle. A simultaneous accept and load keeps word_valid high with the new data.
  - If word_valid=1 and word_ready=0: the completed word is dropped, word_out is unchanged, overflow <= 1.
- Without word completion: word_valid=1 and word_ready=1 clears word_valid on the next cycle.
- Latency: word_valid rises on the clock edge that samples the last bit. It is observed high one cycle after that en cycle.
- clr=1 (synchronous, priority over en):
  - bit_cnt=0, shreg=0, overflow=0.
  - q_prev <= q_in, which resyncs the decode reference.
  - The sample on that cycle is discarded.
  - word_out and word_valid are unaffected, so a pending word survives clr.
- Reset asserted mid-word or with a pending word: all state returns to reset values immediately; the partial word and pending word are lost.
- overflow stays set until clr or reset.

Test Plan:
1. Reset; q_in=0, en=1 for 8 cycles, word_ready=0 -> word_out=0x00, word_valid=1 after the 8th sample, bit_cnt back to 0.
2. Reset; q_in=1,0,1,0,1,0,1,0 on 8 en cycles -> word_out=0xFF.
3. Reset; q_in=1,1,0,1,1,1,0,0 (t=1,0,1,1,0,0,1,0 LSB-first) -> word_out=0x4D. Repeat with en=0 gaps between samples while q_in toggles randomly during gaps -> still 0x4D.
4. Backpressure:
   - word_ready=0; encode 0x4D then 0xA5 -> word_out stays 0x4D and overflow=1 after the second word.
   - Raise word_ready for 1 cycle -> word_valid=0.
   - clr -> overflow=0.
5. Simultaneous accept and load: word_ready=1 on the exact cycle the next word (0x3C) completes -> word_valid stays 1, word_out=0x3C, overflow=0.
6. Mid-operation disturbances:
   - After 3 bits, pulse clr with q_in=1; then encode 0x81 relative to q=1 -> word_out=0x81.
   - Drop rst_n mid-word -> all outputs 0 asynchronously, before the next clock edge.
